fp_rnd_pipe: RTL and testbench
==============================

Name: fp_rnd_pipe

Overview:
- Consumer end of the fp_rnd record emitted by the FMA, div/sqrt and conversion front-ends.
- Takes the unrounded sign, biased exponent, mantissa, GRS bits and special-case flags, applies the IEEE-754 rounding mode, and packs a single (NaN-boxed) or double result with RISC-V fflags.
- Two-stage pipeline with valid/ready backpressure on both sides, so any front-end can stall on a busy writeback port.

Parameters:
- XLEN, 64, result width; single results are NaN-boxed to this width.
- EXPW, 14, width of the incoming biased exponent.
- MANTW, 54, width of the incoming mantissa field.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears both pipeline stages
- rnd_valid  in  1  input record valid
- rnd_ready  out  1  input record accepted when rnd_valid & rnd_ready
- sig  in  1  sign
- expo  in  14  biased exponent; 0 means subnormal or zero
- mant  in  54  double: hidden bit at [52], fraction at [51:0]; single: [53:24]=0, hidden bit at [23]
- grs  in  3  guard, round, sticky
- fmt  in  2  1 = double; any other value = single
- rm  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5..7 treated as RNE
- snan, qnan, dbz, inf, zero, diff  in  1 each  special-case flags from the front-end
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  64  packed result
- fflags  out  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset: out_valid=0, result=0, fflags=0, both stage valids=0; rnd_ready=1 in the first cycle after reset deasserts. Reset mid-operation discards in-flight records with no output.
- Handshake:
  - Stage S2 drives the outputs. S2 loads when it is empty or out_ready=1; S1 advances under the same condition.
  - rnd_ready = ~s1_valid | s1_advance. Full throughput is 1 record/cycle.
  - Latency: 2 cycles from accept to out_valid when not stalled.
  - result and fflags are held stable while out_valid & ~out_ready.
  - Records leave in acceptance order; none are dropped or duplicated.
- S1, rounding:
  - inc = RNE: g&(r|s|lsb); RTZ: 0; RDN: sig&(g|r|s); RUP: ~sig&(g|r|s); RMM: g.
  - lsb is mant[0] for both formats.
  - m1 = mant + inc.
  - Mantissa carry-out (bit 53 double, bit 24 single): shift m1 right 1, e1 = expo+1.
  - Subnormal promotion: expo=0 and the rounded hidden bit becomes set gives e1=1.
  - NX = |grs; UF = NX & (expo==0).
- S2, overflow and packing (EMAX=2047 double, 255 single):
  - e1 >= EMAX gives OF|NX.
  - On overflow, result is infinity when rm is RNE or RMM, RUP with sig=0, or RDN with sig=1. Otherwise the result is max finite (exp EMAX-1, all-ones fraction).
- Special-case priority, highest first; each case overrides the rounding flags:
  - snan: canonical NaN, NV=1 only.
  - qnan: canonical NaN, flags 0.
  - dbz: signed infinity, DZ=1 only.
  - inf: signed infinity, flags 0.
  - zero: signed zero, flags 0. The sign is (rm==RDN) when diff=1, otherwise sig.
- Canonical NaN: 0x7FF8000000000000 for double, 0x7FC00000 for single.
- Single results always carry upper 32 bits = 0xFFFFFFFF.

Test Plan:
- Double 1.0 (expo=1023, mant=0x10000000000000, grs=0, RNE), out_ready=1 → result=0x3FF0000000000000, fflags=0x00, out_valid exactly 2 cycles after accept.
- Tie carry (expo=1023, mant=0x1FFFFFFFFFFFFF, grs=100, RNE) → 0x4000000000000000, fflags=0x01. Same record with RTZ → 0x3FFFFFFFFFFFFFFF, fflags=0x01.
- Single overflow (fmt=0, expo=255, mant=0xFFFFFF, grs=000):
  - RNE → 0xFFFFFFFF7F800000, fflags=0x05.
  - RTZ → 0xFFFFFFFF7F7FFFFF, fflags=0x05.
- Subnormal promotion (fmt=1, expo=0, mant=0x0FFFFFFFFFFFFF, grs=110, RNE) → 0x0010000000000000, fflags=0x03. snan=1 → 0x7FF8000000000000, fflags=0x10. zero=1, diff=1, rm=RDN → 0x8000000000000000, fflags=0x00.
- Backpressure: 4 back-to-back records with out_ready=0 for 5 cycles.
  - rnd_ready drops after 2 accepts, not before.
  - result is stable while stalled.
  - All 4 records emerge in order once out_ready=1, one per cycle.
- Reset while 2 records are in flight → out_valid=0 the cycle after reset. No stale record appears afterwards. The next accepted record produces a correct result 2 cycles later.

Source files
------------

// File: rtl/fp_rnd_if.sv
// Record and result bundle between a rounding front-end (master) and fp_rnd_pipe (slave).
interface fp_rnd_if #(
  parameter int XLEN  = 64,
  parameter int EXPW  = 14,
  parameter int MANTW = 54
);
  logic             rnd_valid;
  logic             rnd_ready;
  logic             sig;
  logic [EXPW-1:0]  expo;
  logic [MANTW-1:0] mant;
  logic [2:0]       grs;
  logic [1:0]       fmt;
  logic [2:0]       rm;
  logic             snan;
  logic             qnan;
  logic             dbz;
  logic             inf;
  logic             zero;
  logic             diff;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [4:0]       fflags;

  modport master (
    output rnd_valid, sig, expo, mant, grs, fmt, rm,
           snan, qnan, dbz, inf, zero, diff, out_ready,
    input  rnd_ready, out_valid, result, fflags
  );

  modport slave (
    input  rnd_valid, sig, expo, mant, grs, fmt, rm,
           snan, qnan, dbz, inf, zero, diff, out_ready,
    output rnd_ready, out_valid, result, fflags
  );
endinterface

// File: rtl/fp_rnd_pipe.sv
// Two-stage IEEE-754 rounding/packing pipe: S1 rounds and adjusts the exponent,
// S2 resolves overflow and special cases and NaN-boxes single results.
module fp_rnd_pipe #(
  parameter int XLEN  = 64,
  parameter int EXPW  = 14,
  parameter int MANTW = 54
) (
  input logic     clock,
  input logic     reset,
  fp_rnd_if.slave bus
);
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [EXPW:0] EMAX_D = (EXPW+1)'(2047);
  localparam logic [EXPW:0] EMAX_S = (EXPW+1)'(255);

  function automatic logic [XLEN-1:0] pack(input logic dbl, input logic sgn,
                                           input logic [10:0] ex, input logic [51:0] fr);
    if (dbl) return {sgn, ex, fr};
    return {32'hFFFF_FFFF, sgn, ex[7:0], fr[22:0]};
  endfunction

  function automatic logic [XLEN-1:0] canon_nan(input logic dbl);
    if (dbl) return 64'h7FF8_0000_0000_0000;
    return 64'hFFFF_FFFF_7FC0_0000;
  endfunction

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s2_valid;
  logic s2_load;
  logic accept;

  assign s2_load       = ~s2_valid | bus.out_ready;
  assign bus.rnd_ready = ~s1_valid | s2_load;
  assign accept        = bus.rnd_valid & bus.rnd_ready;

  // ---------------- S1: rounding ----------------
  logic             fmt_dbl;
  logic             g_bit;
  logic             r_bit;
  logic             s_bit;
  logic             inc;
  logic             carry;
  logic             hidden;
  logic [MANTW-1:0] m1;
  logic [MANTW-2:0] m_adj;
  logic [51:0]      frac1;
  logic [EXPW:0]    e1;

  always_comb begin
    fmt_dbl = (bus.fmt == 2'd1);
    {g_bit, r_bit, s_bit} = bus.grs;
    case (bus.rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = bus.sig & (g_bit | r_bit | s_bit);
      RM_RUP:  inc = ~bus.sig & (g_bit | r_bit | s_bit);
      RM_RMM:  inc = g_bit;
      default: inc = g_bit & (r_bit | s_bit | bus.mant[0]);
    endcase
    m1     = bus.mant + MANTW'(inc);
    carry  = fmt_dbl ? m1[53] : m1[24];
    m_adj  = carry ? m1[MANTW-1:1] : m1[MANTW-2:0];
    hidden = fmt_dbl ? m_adj[52] : m_adj[23];
    frac1  = fmt_dbl ? m_adj[51:0] : {29'd0, m_adj[22:0]};
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (carry)
      e1 = {1'b0, bus.expo} + (EXPW+1)'(1);
    else if ((bus.expo == '0) && hidden)
      e1 = (EXPW+1)'(1);
    else
      e1 = {1'b0, bus.expo};
  end

  logic          s1_sig;
  logic [EXPW:0] s1_exp;
  logic [51:0]   s1_frac;
  logic          s1_dbl;
  logic [2:0]    s1_rm;
  logic          s1_nx;
  logic          s1_uf;
  logic          s1_snan;
  logic          s1_qnan;
  logic          s1_dbz;
  logic          s1_inf;
  logic          s1_zero;
  logic          s1_diff;

  always_ff @(posedge clock) begin
    if (reset)
      s1_valid <= 1'b0;
    else if (bus.rnd_ready)
      s1_valid <= bus.rnd_valid;
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      s1_sig  <= bus.sig;
      s1_exp  <= e1;
      s1_frac <= frac1;
      s1_dbl  <= fmt_dbl;
      s1_rm   <= bus.rm;
      s1_nx   <= |bus.grs;
      s1_uf   <= (|bus.grs) & (bus.expo == '0);
      s1_snan <= bus.snan;
      s1_qnan <= bus.qnan;
      s1_dbz  <= bus.dbz;
      s1_inf  <= bus.inf;
      s1_zero <= bus.zero;
      s1_diff <= bus.diff;
    end
  end

  // ---------------- S2: overflow, specials, packing ----------------
  logic [EXPW:0]   emax;
  logic            ovf;
  logic            ovf_inf;
  logic            zero_sign;
  logic [XLEN-1:0] res_c;
  logic [4:0]      flg_c;

  always_comb begin
    emax = s1_dbl ? EMAX_D : EMAX_S;
    ovf  = (s1_exp >= emax);
    case (s1_rm)
      RM_RTZ:  ovf_inf = 1'b0;
      RM_RDN:  ovf_inf = s1_sig;
      RM_RUP:  ovf_inf = ~s1_sig;
      default: ovf_inf = 1'b1;
    endcase
    zero_sign = s1_diff ? (s1_rm == RM_RDN) : s1_sig;
    res_c = pack(s1_dbl, s1_sig, s1_exp[10:0], s1_frac);
    flg_c = {3'b000, s1_uf, s1_nx};
    if (s1_snan) begin
      res_c = canon_nan(s1_dbl);
      flg_c = 5'b10000;
    end else if (s1_qnan) begin
      res_c = canon_nan(s1_dbl);
      flg_c = 5'b00000;
    end else if (s1_dbz) begin
      res_c = pack(s1_dbl, s1_sig, emax[10:0], 52'd0);
      flg_c = 5'b01000;
    end else if (s1_inf) begin
      res_c = pack(s1_dbl, s1_sig, emax[10:0], 52'd0);
      flg_c = 5'b00000;
    end else if (s1_zero) begin
      res_c = pack(s1_dbl, zero_sign, 11'd0, 52'd0);
      flg_c = 5'b00000;
    end else if (ovf) begin
      res_c = ovf_inf ? pack(s1_dbl, s1_sig, emax[10:0], 52'd0)
                      : pack(s1_dbl, s1_sig, emax[10:0] - 11'd1, {52{1'b1}});
      flg_c = {2'b00, 1'b1, s1_uf, 1'b1};
    end
  end

  logic [XLEN-1:0] s2_result;
  logic [4:0]      s2_fflags;

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_fflags <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= res_c;
        s2_fflags <= flg_c;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.fflags    = s2_fflags;
endmodule

// File: tb/tb_fp_rnd_pipe.sv
// Directed self-checking bench for fp_rnd_pipe: rounding modes, overflow, specials,
// backpressure ordering and mid-flight reset.
module tb_fp_rnd_pipe;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fp_rnd_if #(.XLEN(64), .EXPW(14), .MANTW(54)) bus ();

  fp_rnd_pipe #(.XLEN(64), .EXPW(14), .MANTW(54)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        s;
    logic [13:0] e;
    logic [53:0] m;
    logic [2:0]  g;
    logic [1:0]  f;
    logic [2:0]  r;
    logic [5:0]  sp;  // {snan,qnan,dbz,inf,zero,diff}
    logic [63:0] xr;
    logic [4:0]  xf;
  } vec_t;

  function automatic vec_t mk(input string n, input logic s, input int e, input logic [53:0] m,
                              input logic [2:0] g, input logic [1:0] f, input logic [2:0] r,
                              input logic [5:0] sp, input logic [63:0] xr, input logic [4:0] xf);
    vec_t v;
    v.name = n; v.s = s; v.e = 14'(e); v.m = m; v.g = g; v.f = f; v.r = r;
    v.sp = sp; v.xr = xr; v.xf = xf;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    bus.sig  = v.s;
    bus.expo = v.e;
    bus.mant = v.m;
    bus.grs  = v.g;
    bus.fmt  = v.f;
    bus.rm   = v.r;
    {bus.snan, bus.qnan, bus.dbz, bus.inf, bus.zero, bus.diff} = v.sp;
  endtask

  task automatic send_one(output logic lat_ok, output logic [63:0] res, output logic [4:0] fl);
    logic rdy;
    logic v_early;
    bus.out_ready = 1'b1;
    bus.rnd_valid = 1'b1;
    #1;
    rdy = bus.rnd_ready;
    @(posedge clock);
    #1;
    bus.rnd_valid = 1'b0;
    v_early = bus.out_valid;
    @(posedge clock);
    #1;
    lat_ok = rdy && !v_early && bus.out_valid;
    res = bus.result;
    fl  = bus.fflags;
  endtask

  task automatic test_reset();
    vec_t v;
    v = mk("idle", 0, 0, 54'd0, 3'd0, 2'd1, 3'd0, 6'd0, 64'd0, 5'd0);
    apply_vec(v);
    bus.rnd_valid = 1'b0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h required 0", bus.result); end
    checks++; if (bus.fflags !== 5'd0) begin errors++; $display("FAIL reset_fflags: got %h required 0", bus.fflags); end
    checks++; if (bus.rnd_ready !== 1'b1) begin errors++; $display("FAIL reset_rnd_ready: got %b required 1", bus.rnd_ready); end
  endtask

  task automatic test_double_round();
    vec_t vs[$];
    logic lat_ok; logic [63:0] res; logic [4:0] fl;
    vs.push_back(mk("dbl_one",      0, 1023, 54'h10000000000000, 3'b000, 2'd1, 3'd0, 6'd0, 64'h3FF0000000000000, 5'h00));
    vs.push_back(mk("tie_carry_rne",0, 1023, 54'h1FFFFFFFFFFFFF, 3'b100, 2'd1, 3'd0, 6'd0, 64'h4000000000000000, 5'h01));
    vs.push_back(mk("tie_carry_rtz",0, 1023, 54'h1FFFFFFFFFFFFF, 3'b100, 2'd1, 3'd1, 6'd0, 64'h3FFFFFFFFFFFFFFF, 5'h01));
    vs.push_back(mk("subn_promote", 0, 0,    54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd0, 6'd0, 64'h0010000000000000, 5'h03));
    vs.push_back(mk("subn_stay",    0, 0,    54'h00000000000001, 3'b001, 2'd1, 3'd1, 6'd0, 64'h0000000000000001, 5'h03));
    foreach (vs[i]) begin
      apply_vec(vs[i]);
      send_one(lat_ok, res, fl);
      checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL %s latency: got %b required 1", vs[i].name, lat_ok); end
      checks++; if (res !== vs[i].xr) begin errors++; $display("FAIL %s result: got %h required %h", vs[i].name, res, vs[i].xr); end
      checks++; if (fl !== vs[i].xf) begin errors++; $display("FAIL %s fflags: got %h required %h", vs[i].name, fl, vs[i].xf); end
    end
  endtask

  task automatic test_single();
    vec_t vs[$];
    logic lat_ok; logic [63:0] res; logic [4:0] fl;
    vs.push_back(mk("sgl_ovf_rne",  0, 255, 54'hFFFFFF, 3'b000, 2'd0, 3'd0, 6'd0, 64'hFFFFFFFF7F800000, 5'h05));
    vs.push_back(mk("sgl_ovf_rtz",  0, 255, 54'hFFFFFF, 3'b000, 2'd0, 3'd1, 6'd0, 64'hFFFFFFFF7F7FFFFF, 5'h05));
    vs.push_back(mk("sgl_one",      0, 127, 54'h800000, 3'b000, 2'd2, 3'd0, 6'd0, 64'hFFFFFFFF3F800000, 5'h00));
    vs.push_back(mk("sgl_rup_carry",0, 127, 54'hFFFFFF, 3'b001, 2'd0, 3'd3, 6'd0, 64'hFFFFFFFF40000000, 5'h01));
    foreach (vs[i]) begin
      apply_vec(vs[i]);
      send_one(lat_ok, res, fl);
      checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL %s latency: got %b required 1", vs[i].name, lat_ok); end
      checks++; if (res !== vs[i].xr) begin errors++; $display("FAIL %s result: got %h required %h", vs[i].name, res, vs[i].xr); end
      checks++; if (fl !== vs[i].xf) begin errors++; $display("FAIL %s fflags: got %h required %h", vs[i].name, fl, vs[i].xf); end
    end
  endtask

  task automatic test_modes();
    vec_t vs[$];
    logic lat_ok; logic [63:0] res; logic [4:0] fl;
    vs.push_back(mk("rdn_neg",      1, 1023, 54'h10000000000000, 3'b001, 2'd1, 3'd2, 6'd0, 64'hBFF0000000000001, 5'h01));
    vs.push_back(mk("rup_neg",      1, 1023, 54'h10000000000000, 3'b001, 2'd1, 3'd3, 6'd0, 64'hBFF0000000000000, 5'h01));
    vs.push_back(mk("rmm_tie",      0, 1023, 54'h10000000000000, 3'b100, 2'd1, 3'd4, 6'd0, 64'h3FF0000000000001, 5'h01));
    vs.push_back(mk("rne_tie_even", 0, 1023, 54'h10000000000000, 3'b100, 2'd1, 3'd0, 6'd0, 64'h3FF0000000000000, 5'h01));
    vs.push_back(mk("rm7_as_rne",   0, 1023, 54'h10000000000000, 3'b110, 2'd1, 3'd7, 6'd0, 64'h3FF0000000000001, 5'h01));
    vs.push_back(mk("ovf_rdn_pos",  0, 2047, 54'h10000000000000, 3'b000, 2'd1, 3'd2, 6'd0, 64'h7FEFFFFFFFFFFFFF, 5'h05));
    vs.push_back(mk("ovf_rdn_neg",  1, 2047, 54'h10000000000000, 3'b000, 2'd1, 3'd2, 6'd0, 64'hFFF0000000000000, 5'h05));
    foreach (vs[i]) begin
      apply_vec(vs[i]);
      send_one(lat_ok, res, fl);
      checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL %s latency: got %b required 1", vs[i].name, lat_ok); end
      checks++; if (res !== vs[i].xr) begin errors++; $display("FAIL %s result: got %h required %h", vs[i].name, res, vs[i].xr); end
      checks++; if (fl !== vs[i].xf) begin errors++; $display("FAIL %s fflags: got %h required %h", vs[i].name, fl, vs[i].xf); end
    end
  endtask

  task automatic test_specials();
    vec_t vs[$];
    logic lat_ok; logic [63:0] res; logic [4:0] fl;
    vs.push_back(mk("snan_dbl",     0, 0, 54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd0, 6'b100000, 64'h7FF8000000000000, 5'h10));
    vs.push_back(mk("snan_over_q",  0, 0, 54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd0, 6'b110000, 64'h7FF8000000000000, 5'h10));
    vs.push_back(mk("qnan_sgl",     0, 0, 54'h0,              3'b110, 2'd0, 3'd0, 6'b010000, 64'hFFFFFFFF7FC00000, 5'h00));
    vs.push_back(mk("dbz_neg",      1, 0, 54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd0, 6'b001000, 64'hFFF0000000000000, 5'h08));
    vs.push_back(mk("dbz_over_inf", 0, 0, 54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd0, 6'b001100, 64'h7FF0000000000000, 5'h08));
    vs.push_back(mk("inf_sgl_neg",  1, 0, 54'h0,              3'b110, 2'd0, 3'd0, 6'b000100, 64'hFFFFFFFFFF800000, 5'h00));
    vs.push_back(mk("zero_diff_rdn",0, 0, 54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd2, 6'b000011, 64'h8000000000000000, 5'h00));
    vs.push_back(mk("zero_diff_rne",1, 0, 54'h0FFFFFFFFFFFFF, 3'b110, 2'd1, 3'd0, 6'b000011, 64'h0000000000000000, 5'h00));
    vs.push_back(mk("zero_sgl_neg", 1, 0, 54'h0,              3'b110, 2'd0, 3'd2, 6'b000010, 64'hFFFFFFFF80000000, 5'h00));
    foreach (vs[i]) begin
      apply_vec(vs[i]);
      send_one(lat_ok, res, fl);
      checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL %s latency: got %b required 1", vs[i].name, lat_ok); end
      checks++; if (res !== vs[i].xr) begin errors++; $display("FAIL %s result: got %h required %h", vs[i].name, res, vs[i].xr); end
      checks++; if (fl !== vs[i].xf) begin errors++; $display("FAIL %s fflags: got %h required %h", vs[i].name, fl, vs[i].xf); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_res [4];
    logic [63:0] got_res [4];
    int          got_cyc [4];
    logic        rdy_hist [5];
    logic        rdy;
    logic        xfer;
    logic [63:0] cur;
    int          sent;
    int          got;
    int          stalls;
    int          early_accepts;
    vec_t        v;
    for (int k = 0; k < 4; k++)
      exp_res[k] = 64'h3FF0000000000000 | 64'(k + 1);
    bus.out_ready = 1'b1;
    bus.rnd_valid = 1'b0;
    @(posedge clock);
    #1;
    sent = 0; got = 0; stalls = 0; early_accepts = 0;
    v = mk("b2b", 0, 1023, 54'h10000000000000 | 54'(sent + 1), 3'b000, 2'd1, 3'd0, 6'd0, 64'd0, 5'd0);
    apply_vec(v);
    bus.rnd_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.out_ready = (cyc >= 5);
      #1;
      rdy  = bus.rnd_ready;
      xfer = bus.out_valid & bus.out_ready;
      cur  = bus.result;
      if (cyc < 5) rdy_hist[cyc] = rdy;
      if (cyc >= 2 && cyc < 5) begin
        stalls++;
        checks++;
        if (bus.out_valid !== 1'b1 || cur !== exp_res[0]) begin
          errors++;
          $display("FAIL stall_hold cyc%0d: got valid=%b result=%h required valid=1 result=%h", cyc, bus.out_valid, cur, exp_res[0]);
        end
      end
      @(posedge clock);
      #1;
      if (bus.rnd_valid && rdy) begin
        sent++;
        if (cyc < 5) early_accepts++;
        if (sent < 4) begin
          v = mk("b2b", 0, 1023, 54'h10000000000000 | 54'(sent + 1), 3'b000, 2'd1, 3'd0, 6'd0, 64'd0, 5'd0);
          apply_vec(v);
        end else begin
          bus.rnd_valid = 1'b0;
        end
      end
      if (xfer) begin
        got_res[got] = cur;
        got_cyc[got] = cyc;
        got++;
      end
    end
    bus.rnd_valid = 1'b0;
    checks++; if (early_accepts !== 2) begin errors++; $display("FAIL b2b_accepts_while_stalled: got %0d required 2", early_accepts); end
    checks++; if (rdy_hist[0] !== 1'b1 || rdy_hist[1] !== 1'b1 || rdy_hist[2] !== 1'b0) begin
      errors++; $display("FAIL b2b_ready_drop: got %b%b%b required 110", rdy_hist[0], rdy_hist[1], rdy_hist[2]);
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count: got %0d required 4", got); end
    for (int k = 0; k < got; k++) begin
      checks++; if (got_res[k] !== exp_res[k]) begin errors++; $display("FAIL b2b_order%0d: got %h required %h", k, got_res[k], exp_res[k]); end
      checks++; if (got_cyc[k] !== got_cyc[0] + k) begin errors++; $display("FAIL b2b_rate%0d: got cycle %0d required %0d", k, got_cyc[k], got_cyc[0] + k); end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid %b required 0", bus.out_valid); end
  endtask

  task automatic test_reset_midflight();
    vec_t va;
    vec_t vb;
    vec_t vc;
    int   stale;
    logic lat_ok; logic [63:0] res; logic [4:0] fl;
    va = mk("rst_a", 0, 1023, 54'h10000000000000, 3'b000, 2'd1, 3'd0, 6'd0, 64'd0, 5'd0);
    vb = mk("rst_b", 1, 1023, 54'h10000000000000, 3'b000, 2'd1, 3'd0, 6'd0, 64'd0, 5'd0);
    vc = mk("after_reset", 0, 1023, 54'h1FFFFFFFFFFFFF, 3'b100, 2'd1, 3'd0, 6'd0, 64'h4000000000000000, 5'h01);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    apply_vec(va);
    bus.rnd_valid = 1'b1;
    @(posedge clock);
    #1;
    apply_vec(vb);
    @(posedge clock);
    #1;
    bus.rnd_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL inflight_before_reset: got out_valid %b required 1", bus.out_valid); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_flush: got out_valid %b required 0", bus.out_valid); end
    reset = 1'b0;
    stale = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (bus.out_valid) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL stale_after_reset: got %0d valid cycles required 0", stale); end
    apply_vec(vc);
    send_one(lat_ok, res, fl);
    checks++; if (lat_ok !== 1'b1) begin errors++; $display("FAIL %s latency: got %b required 1", vc.name, lat_ok); end
    checks++; if (res !== vc.xr) begin errors++; $display("FAIL %s result: got %h required %h", vc.name, res, vc.xr); end
    checks++; if (fl !== vc.xf) begin errors++; $display("FAIL %s fflags: got %h required %h", vc.name, fl, vc.xf); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.rnd_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_double_round();
    test_single();
    test_modes();
    test_specials();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
